// File: rtl/fun_inv_pkg.sv
// Shared constants and state encoding for the fun_inv cube-of-quotient unit.
package fun_inv_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 24;
  localparam int ITER  = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SQR  = 2'd2,
    CUBE = 2'd3
  } state_t;

endpackage

// File: rtl/add24.sv
// Single 24-bit adder shared by every arithmetic step of fun_inv.
module add24
  import fun_inv_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic             cin,
  output logic [RES_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{RES_W{1'b0}}, cin};

endmodule

// File: rtl/fun_inv.sv
// fun_inv: result = (a / b)^3 via restoring divide then two shift-add multiplies.
// Optional remainder output enabled by defining FUN_INV_REM_EN.
//
// state | meaning
// IDLE  | waiting for start, result held
// DIV   | restoring division, one quotient bit per cycle MSB first
// SQR   | q*q shift-add, one multiplier bit per cycle
// CUBE  | (q*q)*q shift-add, result written on exit
module fun_inv
  import fun_inv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic             busy,
  output logic [RES_W-1:0] result
`ifdef FUN_INV_REM_EN
  ,
  output logic [OP_W-1:0]  rem
`endif
);

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  dvd;     // dividend shifting out, quotient shifting in
  logic [OP_W-1:0]  dvs;
  logic [OP_W-1:0]  prem;
  logic [RES_W-1:0] mcand;
  logic [OP_W-1:0]  mplier;
  logic [RES_W-1:0] acc;

  logic [RES_W-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [OP_W-1:0]  q_nx;
  logic             last;

  assign last = (cnt == CNT_W'(ITER - 1));
  assign q_nx = {dvd[OP_W-2:0], add_cout};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = DIV;
      DIV:     if (last)  state_nx = SQR;
      SQR:     if (last)  state_nx = CUBE;
      CUBE:    if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Division subtracts via inverted operand + carry-in; cout=1 means no borrow.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      DIV: begin
        add_a   = {{(RES_W-OP_W-1){1'b0}}, prem, dvd[OP_W-1]};
        add_b   = ~{{(RES_W-OP_W){1'b0}}, dvs};
        add_cin = 1'b1;
      end
      SQR, CUBE: begin
        add_a = acc;
        add_b = mplier[0] ? mcand : '0;
      end
      default: ;
    endcase
  end

  add24 u_add24 (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
`ifdef FUN_INV_REM_EN
      rem    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd  <= a_i;
            dvs  <= b_i;
            prem <= '0;
            cnt  <= '0;
          end
        end
        DIV: begin
          prem <= add_cout ? add_sum[OP_W-1:0] : {prem[OP_W-2:0], dvd[OP_W-1]};
          dvd  <= q_nx;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{(RES_W-OP_W){1'b0}}, q_nx};
            mplier <= q_nx;
          end
        end
        SQR: begin
          acc    <= add_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= add_sum;
            mplier <= dvd;
          end
        end
        CUBE: begin
          acc    <= add_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            cnt    <= '0;
            result <= add_sum;
`ifdef FUN_INV_REM_EN
            rem    <= prem;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fun_inv.md
FUN_INV -- requirements
Module: fun_inv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled only while idle.
REQ-004 SHALL have port a_i, input, 8 bits: dividend, unsigned.
REQ-005 SHALL have port b_i, input, 8 bits: divisor, unsigned.
REQ-006 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 SHALL have port result, output, 24 bits: (floor(a/b))^3, unsigned.
REQ-008 SHALL have port rem, output, 8 bits: a mod b; present only when FUN_INV_REM_EN is defined.

Function
REQ-009 SHALL use states IDLE, DIV, SQR and CUBE.
- IDLE->DIV on start=1.
- DIV->SQR after 8 cycles.
- SQR->CUBE after 8 cycles.
- CUBE->IDLE after 8 cycles.
REQ-010 SHALL, in IDLE with start=1, capture a_i and b_i into internal registers on that edge; later input changes SHALL NOT affect the operation.
REQ-011 SHALL assert busy combinationally whenever state != IDLE: high exactly 24 cycles, starting the cycle after the start-sampling edge.
REQ-012 SHALL ignore start while busy, with no queuing.
REQ-013 SHALL compute the 8-bit quotient q in DIV by restoring division, one quotient bit per cycle, MSB first.
REQ-014 SHALL compute q*q (16 bits) in SQR by shift-add, one multiplier bit of q per cycle.
REQ-015 SHALL compute (q*q)*q (24 bits) in CUBE by shift-add, one multiplier bit of q per cycle; no overflow is possible (255^3 < 2^24).
REQ-016 SHALL perform every addition and subtraction through one shared 24-bit adder instance; subtraction SHALL be an add of the inverted operand with carry-in 1; no other adders SHALL exist in the datapath.
REQ-017 SHALL update result only on the CUBE->IDLE edge and hold it until the next completion or reset; result SHALL NOT show intermediate values.
REQ-018 SHALL, when b=0, produce q=8'hFF and remainder=a (natural restoring-divider outcome), giving result=24'hFD02FF; no error signalling.
REQ-019 SHALL, when a<b, produce q=0 and result=0, still taking the full 24-cycle latency.
REQ-020 SHALL accept a start presented in the same cycle that busy falls (state IDLE), beginning the next operation immediately.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, set state=IDLE, busy=0, result=0, rem=0 (if present), and clear all datapath registers.
REQ-022 SHALL, on reset mid-operation, abandon the operation, leave result at 0, and produce no completion.
REQ-023 SHALL give rst priority over start when both are high on the same edge, so no operation begins.

Configuration
REQ-024 SHALL, with FUN_INV_REM_EN defined, provide port rem, updated on the same edge as result with the final DIV partial remainder.
REQ-025 SHALL, with FUN_INV_REM_EN undefined, have no rem port, no remainder output register, and otherwise identical timing and results.

Structure
REQ-026 SHALL place the state encoding (IDLE=0, DIV=1, SQR=2, CUBE=3), the operand width (8), the result width (24) and the iteration count (8) in shared package fun_inv_pkg.
REQ-027 SHALL implement the shared 24-bit adder as sub-module add24 (a, b, cin -> sum, cout), instantiated exactly once and muxed by state.
REQ-028 SHALL keep one 3-bit iteration counter shared by all three phases, reset to 0 on each phase entry.

Verification
REQ-029 SHALL be verified by directed bench scenario: a=27, b=3, start 1 cycle -> busy high 24 cycles, then result=24'h0002D9 (729), rem=0.
REQ-030 SHALL be verified by directed bench scenario: a=255, b=1 -> result=24'hFD02FF (16581375), rem=0.
REQ-031 SHALL be verified by directed bench scenario: a=5, b=7 -> result=0, rem=5, latency still 24 cycles.
REQ-032 SHALL be verified by directed bench scenario: a=100, b=0 -> result=24'hFD02FF, rem=100.
REQ-033 SHALL be verified by directed bench scenario: a=64, b=4 started, then start pulsed with a=9, b=1 at busy cycle 5 -> second start ignored, result=24'h001000 (4096).
REQ-034 SHALL be verified by directed bench scenario: a=200, b=2 started, rst asserted at busy cycle 10 -> next cycle busy=0, result=0, and no later completion.
